tag_table_writer: RTL and testbench
===================================

# tag_table_writer

Write/allocation side of the prefetcher's associative tag table. The block owns the tag storage and per-entry valid bits and inserts new tags, either reusing a matching valid entry or allocating a free or evicted slot. It also supports single-entry invalidation and a full flush. Its `tag_mat` and `valid_vec` outputs drive the combinational tag-lookup (match-index) logic on the read side.

## Interface

- `LOG_VEC_SIZE`, default 6: log2 of the number of entries.
- `VEC_SIZE`, default `1<<LOG_VEC_SIZE`: number of entries.
- `TAG_SIZE`, default 64: tag width in bits.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `resetN`  in  1: asynchronous, active-low reset.
- `wr_valid`  in  1: insert request.
- `wr_tag`  in  TAG_SIZE: tag to insert; sampled on accept.
- `wr_ready`  out  1: block can accept an insert.
- `inv_valid`  in  1: invalidate one entry.
- `inv_idx`  in  LOG_VEC_SIZE: entry to invalidate.
- `flush`  in  1: clear all valid bits and abort any pending insert.
- `tag_mat`  out  VEC_SIZE x TAG_SIZE: registered tag storage.
- `valid_vec`  out  VEC_SIZE: registered valid bits.
- `rsp_valid`  out  1: one-cycle insert-completion pulse.
- `rsp_idx`  out  LOG_VEC_SIZE: entry index used by the completed insert.
- `rsp_hit`  out  1: the tag was already present; the table is unchanged.
- `rsp_evict`  out  1: a valid entry was overwritten.
- `full`  out  1: all valid bits are set (AND-reduction of `valid_vec`).
- `count`  out  LOG_VEC_SIZE+1: popcount of `valid_vec`.

## Operation

- **Reset values:** `tag_mat` = 0 and `valid_vec` = 0; `rr_ptr` = 0; FSM in IDLE; `rsp_*` = 0; `wr_ready` = 1.
- **FSM states:**
  - **IDLE:** `wr_ready` = !`flush`. An accept occurs when `wr_valid` and `wr_ready` are both 1. On accept, `wr_tag` is latched into `pend_tag` and the FSM moves to COMMIT.
  - **COMMIT:** `wr_ready` = 0. The block resolves and writes the insert, then returns to IDLE unconditionally.
- **Resolution in COMMIT** uses `valid_vec` as it stands at the start of the cycle. Priority order:
  - **Hit:** some valid entry has `tag_mat[i] == pend_tag`. `rsp_idx` = the lowest such `i`, `rsp_hit` = 1, no write.
  - **Free entry:** else, if some `valid_vec[i] == 0`, `rsp_idx` = the lowest such `i`. Write `tag_mat[i] <= pend_tag` and `valid_vec[i] <= 1`; `rsp_evict` = 0.
  - **Evict:** else, `rsp_idx` = `rr_ptr`. Overwrite that entry's tag, keep it valid, set `rsp_evict` = 1, and increment `rr_ptr` modulo VEC_SIZE.
  - `rr_ptr` changes only on an eviction.
- **Invalidate:** accepted in any state. `valid_vec[inv_idx] <= 0`; the tag contents are kept.
- **Same-cycle collision (COMMIT and invalidate):**
  - If `inv_idx` equals the index being written by a free-entry or evict insert, the write wins and the entry ends valid.
  - If `inv_idx` equals the index of a hit, the hit is still reported and the entry ends invalid.
  - Invalidating a different index is applied normally. The freed slot is not visible to the resolution in that same cycle.
- **Flush:** highest priority.
  - Same cycle: `valid_vec` <= 0, `rr_ptr` <= 0, FSM <= IDLE, and no response is produced for any pending insert.
  - `tag_mat` is not cleared.
  - `wr_ready` = 0 during any cycle in which `flush` = 1.
- **Responses:** `rsp_idx`, `rsp_hit` and `rsp_evict` are registered and hold their values until the next response. `rsp_valid` is a single-cycle pulse.
- `count` and `full` are combinational from `valid_vec`.

## Timing

- Insert accepted in cycle k:
  - k+1: COMMIT; the table is updated at the end of the cycle.
  - k+2: `rsp_valid` = 1, and the new `tag_mat`/`valid_vec` are visible; `wr_ready` = 1 again.
- Maximum throughput is one insert per 2 cycles.
- Invalidation takes effect on `valid_vec` one cycle after `inv_valid`.
- Flush takes effect on `valid_vec` one cycle after `flush`.
- Reset assertion is asynchronous and may occur mid-COMMIT. It forces all reset values immediately, and no response is produced.

## Test plan

Bench configuration: LOG_VEC_SIZE=2, TAG_SIZE=8.

- **Reset:** assert and release `resetN` -> `valid_vec`=0000, `count`=0, `full`=0, `wr_ready`=1, `rsp_valid`=0.
- **Fill:** insert 0x11, 0x22, 0x33, 0x44 back-to-back, honouring `wr_ready` ->
  - responses with `rsp_idx` 0, 1, 2, 3 respectively, each with `hit`=0 and `evict`=0, each 2 cycles after its accept;
  - `full`=1 and `count`=4 after the last response.
- **Hit:** insert 0x22 on the full table -> `rsp_hit`=1, `rsp_idx`=1, `rsp_evict`=0, `tag_mat` unchanged.
- **Round-robin eviction:** on the full table insert 0x55 then 0x66 ->
  - 0x55 gets `rsp_idx`=0 with `evict`=1; 0x66 gets `rsp_idx`=1 with `evict`=1;
  - `rr_ptr` ends at 2;
  - then insert 0x55 -> hit at index 0.
- **Invalidate and reuse:** invalidate index 3, then insert 0x77 -> `rsp_idx`=3, `evict`=0, `rr_ptr` still 2.
- **Collision and flush:**
  - Assert `inv_idx`=2 during a COMMIT whose resolution writes index 2 -> index 2 ends valid.
  - Assert `flush` during COMMIT -> no `rsp_valid`, `valid_vec`=0000 and `count`=0 the next cycle. A following insert of 0x99 gets `rsp_idx`=0 with `evict`=0.

Source files
------------

// File: rtl/tag_table_writer.sv
// Write/allocation side of the prefetcher tag table: owns tag storage and valid bits,
// inserts tags (hit reuse, free-slot fill or round-robin eviction), invalidates and flushes.
module tag_table_writer #(
    parameter int unsigned LOG_VEC_SIZE = 6,
    parameter int unsigned VEC_SIZE     = 1 << LOG_VEC_SIZE,
    parameter int unsigned TAG_SIZE     = 64
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic                               wr_valid,
    input  logic [TAG_SIZE-1:0]                wr_tag,
    output logic                               wr_ready,
    input  logic                               inv_valid,
    input  logic [LOG_VEC_SIZE-1:0]            inv_idx,
    input  logic                               flush,
    output logic [VEC_SIZE-1:0][TAG_SIZE-1:0]  tag_mat,
    output logic [VEC_SIZE-1:0]                valid_vec,
    output logic                               rsp_valid,
    output logic [LOG_VEC_SIZE-1:0]            rsp_idx,
    output logic                               rsp_hit,
    output logic                               rsp_evict,
    output logic                               full,
    output logic [LOG_VEC_SIZE:0]              count
);

    typedef logic [LOG_VEC_SIZE-1:0] idx_t;
    typedef logic [LOG_VEC_SIZE:0]   cnt_t;
    typedef enum logic [0:0] {StIdle, StCommit} state_e;

    state_e                             state_q, state_d;
    logic [TAG_SIZE-1:0]                pend_tag_q, pend_tag_d;
    logic [VEC_SIZE-1:0][TAG_SIZE-1:0]  tag_q, tag_d;
    logic [VEC_SIZE-1:0]                valid_q, valid_d;
    idx_t                               rr_ptr_q, rr_ptr_d;
    logic                               rsp_valid_q, rsp_valid_d;
    idx_t                               rsp_idx_q, rsp_idx_d;
    logic                               rsp_hit_q, rsp_hit_d;
    logic                               rsp_evict_q, rsp_evict_d;

    logic hit_found;
    idx_t hit_idx;
    logic free_found;
    idx_t free_idx;
    cnt_t cnt;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(VEC_SIZE) - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == pend_tag_q)) begin
                hit_found = 1'b1;
                hit_idx   = idx_t'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = idx_t'(i);
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(VEC_SIZE); i++) begin
            cnt = cnt + cnt_t'(valid_q[i]);
        end
    end

    assign wr_ready = (state_q == StIdle) && !flush;

    always_comb begin
        state_d     = state_q;
        pend_tag_d  = pend_tag_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = 1'b0;
        rsp_idx_d   = rsp_idx_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_evict_d = rsp_evict_q;

        // Applied before the insert write so a colliding write leaves the entry valid.
        if (inv_valid) begin
            valid_d[inv_idx] = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (wr_valid && wr_ready) begin
                    pend_tag_d = wr_tag;
                    state_d    = StCommit;
                end
            end
            StCommit: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                if (hit_found) begin
                    rsp_idx_d   = hit_idx;
                    rsp_hit_d   = 1'b1;
                    rsp_evict_d = 1'b0;
                end else if (free_found) begin
                    tag_d[free_idx]   = pend_tag_q;
                    valid_d[free_idx] = 1'b1;
                    rsp_idx_d         = free_idx;
                    rsp_hit_d         = 1'b0;
                    rsp_evict_d       = 1'b0;
                end else begin
                    tag_d[rr_ptr_q]   = pend_tag_q;
                    valid_d[rr_ptr_q] = 1'b1;
                    rsp_idx_d         = rr_ptr_q;
                    rsp_hit_d         = 1'b0;
                    rsp_evict_d       = 1'b1;
                    rr_ptr_d          = rr_ptr_q + idx_t'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush aborts any pending insert; held response fields stay untouched.
        if (flush) begin
            state_d     = StIdle;
            valid_d     = '0;
            rr_ptr_d    = '0;
            tag_d       = tag_q;
            rsp_valid_d = 1'b0;
            rsp_idx_d   = rsp_idx_q;
            rsp_hit_d   = rsp_hit_q;
            rsp_evict_d = rsp_evict_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            pend_tag_q  <= '0;
            tag_q       <= '0;
            valid_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_evict_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_tag_q  <= pend_tag_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_evict_q <= rsp_evict_d;
        end
    end

    assign tag_mat   = tag_q;
    assign valid_vec = valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_evict = rsp_evict_q;
    assign count     = cnt;
    assign full      = &valid_q;

endmodule

// File: tb/tb_tag_table_writer.sv
// Bench for tag_table_writer: directed test-plan scenarios plus randomized traffic,
// all checked every cycle against a transaction-level table model.
module tb_tag_table_writer;

    localparam int LOG = 2;
    localparam int VEC = 4;
    localparam int TW  = 8;

    logic                     clk = 1'b0;
    logic                     resetN = 1'b0;
    logic                     wr_valid = 1'b0;
    logic [TW-1:0]            wr_tag = '0;
    logic                     wr_ready;
    logic                     inv_valid = 1'b0;
    logic [LOG-1:0]           inv_idx = '0;
    logic                     flush = 1'b0;
    logic [VEC-1:0][TW-1:0]   tag_mat;
    logic [VEC-1:0]           valid_vec;
    logic                     rsp_valid;
    logic [LOG-1:0]           rsp_idx;
    logic                     rsp_hit;
    logic                     rsp_evict;
    logic                     full;
    logic [LOG:0]             count;

    tag_table_writer #(
        .LOG_VEC_SIZE(LOG),
        .TAG_SIZE    (TW)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .wr_valid (wr_valid),
        .wr_tag   (wr_tag),
        .wr_ready (wr_ready),
        .inv_valid(inv_valid),
        .inv_idx  (inv_idx),
        .flush    (flush),
        .tag_mat  (tag_mat),
        .valid_vec(valid_vec),
        .rsp_valid(rsp_valid),
        .rsp_idx  (rsp_idx),
        .rsp_hit  (rsp_hit),
        .rsp_evict(rsp_evict),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Table model: whole-table snapshot semantics, one pending insert at most.
    logic [TW-1:0] m_tag [VEC];
    bit            m_valid [VEC];
    int            m_rr;
    bit            m_busy;
    logic [TW-1:0] m_pend;
    bit            m_rsp_v;
    int            m_rsp_idx;
    bit            m_rsp_hit;
    bit            m_rsp_ev;

    function automatic void m_reset();
        for (int i = 0; i < VEC; i++) begin
            m_tag[i]   = '0;
            m_valid[i] = 1'b0;
        end
        m_rr = 0; m_busy = 0; m_pend = '0;
        m_rsp_v = 0; m_rsp_idx = 0; m_rsp_hit = 0; m_rsp_ev = 0;
    endfunction

    function automatic void m_step();
        bit snap [VEC];
        int idx;
        bit hit;
        m_rsp_v = 0;
        if (flush) begin
            for (int i = 0; i < VEC; i++) m_valid[i] = 1'b0;
            m_rr   = 0;
            m_busy = 0;
            return;
        end
        snap = m_valid;
        if (inv_valid) m_valid[inv_idx] = 1'b0;
        if (m_busy) begin
            idx = -1;
            hit = 0;
            for (int i = 0; i < VEC; i++)
                if (idx < 0 && snap[i] && m_tag[i] == m_pend) begin idx = i; hit = 1; end
            for (int i = 0; i < VEC; i++)
                if (idx < 0 && !snap[i]) idx = i;
            m_rsp_ev = 0;
            if (idx < 0) begin
                idx      = m_rr;
                m_rsp_ev = 1;
                m_rr     = (m_rr + 1) % VEC;
            end
            if (!hit) begin
                m_tag[idx]   = m_pend;
                m_valid[idx] = 1'b1;
            end
            m_rsp_idx = idx;
            m_rsp_hit = hit;
            m_rsp_v   = 1;
            m_busy    = 0;
        end else if (wr_valid) begin
            m_pend = wr_tag;
            m_busy = 1;
        end
    endfunction

    initial m_reset();

    always @(posedge clk) begin
        if (!resetN) m_reset();
        else m_step();
    end

    logic [VEC*TW-1:0] e_tags;
    logic [VEC-1:0]    e_valid;
    int                e_cnt;

    always @(negedge clk) begin
        if (!resetN) m_reset();
        e_cnt = 0;
        for (int i = 0; i < VEC; i++) begin
            e_tags[i*TW +: TW] = m_tag[i];
            e_valid[i]         = m_valid[i];
            e_cnt             += int'(m_valid[i]);
        end
        chk("model valid_vec", valid_vec, e_valid);
        chk("model tag_mat", tag_mat, e_tags);
        chk("model count", count, e_cnt);
        chk("model full", full, e_cnt == VEC);
        chk("model wr_ready", wr_ready, !m_busy && !flush);
        chk("model rsp_valid", rsp_valid, m_rsp_v);
        chk("model rsp_idx", rsp_idx, m_rsp_idx);
        chk("model rsp_hit", rsp_hit, m_rsp_hit);
        chk("model rsp_evict", rsp_evict, m_rsp_ev);
    end

    // One insert; optionally invalidate or flush during its COMMIT cycle.
    task automatic ins(input logic [TW-1:0] tag, input int e_idx, input bit e_hit,
                       input bit e_ev, input bit do_inv, input logic [LOG-1:0] iidx,
                       input bit do_flush, input string nm);
        int w = 0;
        @(posedge clk); #1;
        while (!wr_ready && w < 8) begin
            @(posedge clk); #1;
            w++;
        end
        if (!wr_ready) begin
            chk({nm, " ready timeout"}, 0, 1);
            return;
        end
        wr_valid = 1'b1;
        wr_tag   = tag;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        if (do_inv) begin inv_valid = 1'b1; inv_idx = iidx; end
        if (do_flush) flush = 1'b1;
        @(negedge clk);
        chk({nm, " rsp early"}, rsp_valid, 0);
        @(posedge clk); #1;
        inv_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        if (do_flush) begin
            chk({nm, " no rsp"}, rsp_valid, 0);
        end else begin
            chk({nm, " rsp_valid"}, rsp_valid, 1);
            chk({nm, " rsp_idx"}, rsp_idx, e_idx);
            chk({nm, " rsp_hit"}, rsp_hit, e_hit);
            chk({nm, " rsp_evict"}, rsp_evict, e_ev);
        end
    endtask

    task automatic inv(input logic [LOG-1:0] idx);
        @(posedge clk); #1;
        inv_valid = 1'b1;
        inv_idx   = idx;
        @(posedge clk); #1;
        inv_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        chk("reset valid_vec", valid_vec, 4'b0000);
        chk("reset count", count, 0);
        chk("reset full", full, 0);
        chk("reset wr_ready", wr_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);

        ins(8'h11, 0, 0, 0, 0, 0, 0, "fill 11");
        ins(8'h22, 1, 0, 0, 0, 0, 0, "fill 22");
        ins(8'h33, 2, 0, 0, 0, 0, 0, "fill 33");
        ins(8'h44, 3, 0, 0, 0, 0, 0, "fill 44");
        chk("fill full", full, 1);
        chk("fill count", count, 4);

        ins(8'h22, 1, 1, 0, 0, 0, 0, "hit 22");
        chk("hit tag_mat", tag_mat, 32'h44332211);

        ins(8'h55, 0, 0, 1, 0, 0, 0, "evict 55");
        ins(8'h66, 1, 0, 1, 0, 0, 0, "evict 66");
        ins(8'h55, 0, 1, 0, 0, 0, 0, "rehit 55");

        inv(2'd3);
        @(negedge clk);
        chk("inv3 valid_vec", valid_vec, 4'b0111);
        ins(8'h77, 3, 0, 0, 0, 0, 0, "reuse 77");
        // Next eviction lands on index 2, showing the pointer was left at 2.
        ins(8'h88, 2, 0, 1, 0, 0, 0, "evict 88");

        inv(2'd2);
        ins(8'hAA, 2, 0, 0, 1, 2'd2, 0, "collide AA");
        chk("collide valid_vec", valid_vec, 4'b1111);

        ins(8'hBB, 0, 0, 0, 0, 0, 1, "flush BB");
        chk("flush valid_vec", valid_vec, 4'b0000);
        chk("flush count", count, 0);
        @(negedge clk);
        chk("flush still no rsp", rsp_valid, 0);
        ins(8'h99, 0, 0, 0, 0, 0, 0, "after flush 99");
        chk("tags kept after flush", tag_mat, 32'h77AA6699);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            wr_valid  = ($urandom % 2) == 0;
            wr_tag    = 8'h10 + 8'($urandom % 6);
            inv_valid = ($urandom % 6) == 0;
            inv_idx   = 2'($urandom % VEC);
            flush     = ($urandom % 40) == 0;
            if (($urandom % 300) == 0) begin
                #2 resetN = 1'b0;
                @(posedge clk); #1;
                resetN = 1'b1;
            end
        end
        @(posedge clk); #1;
        wr_valid  = 1'b0;
        inv_valid = 1'b0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
